ay_regs_multi: RTL and testbench

Parametrised register file for one or more AY-3-891x-compatible PSG cores sharing one CPU bus port. It holds the address latch and the 14 sound registers of each chip, masks unused register bits as the original silicon does, and generates an envelope-restart pulse on R13 writes. An optional build feature adds I/O ports A/B (R14/R15) with direction control from R7. It sits between the CPU bus interface (tick-qualified writes/reads) and the per-chip tone/noise/envelope generators.

---
 rtl/ay_regs_multi.sv | 139 +++++++++++++
 tb/tb_ay_regs_multi.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ay_regs_multi.sv
// Register file for CHIPS AY-3-891x PSG banks sharing one CPU bus port.
// Define AY_REGS_IO_EN to add the R14/R15 I/O port latches, pin synchronisers and drive enables.
module ay_regs_multi #(
    parameter int         CHIPS   = 2,
    parameter logic [3:0] ADDR_HI = 4'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHIPS-1:0]     cs,
    input  logic                 a0,
    input  logic                 wr_tick,
    input  logic [7:0]           wdata,
    input  logic                 rd_tick,
    output logic [7:0]           rdata,
    output logic [CHIPS*112-1:0] regs_flat,
    output logic [CHIPS-1:0]     env_restart
`ifdef AY_REGS_IO_EN
    ,
    input  logic [CHIPS*8-1:0]   ioa_in,
    input  logic [CHIPS*8-1:0]   iob_in,
    output logic [CHIPS*8-1:0]   ioa_out,
    output logic [CHIPS*8-1:0]   iob_out,
    output logic [CHIPS-1:0]     ioa_oe,
    output logic [CHIPS-1:0]     iob_oe
`endif
);

    // Entries 14/15 are the I/O output latches; they stay 0 when the ports are absent.
    logic [7:0] regs_q [CHIPS][16];
    logic [3:0] addr_q [CHIPS];
    logic       addr_ok_q [CHIPS];
    logic [7:0] rd_val;

`ifdef AY_REGS_IO_EN
    localparam logic IO_EN = 1'b1;
    logic [7:0] ioa_s1 [CHIPS];
    logic [7:0] ioa_s2 [CHIPS];
    logic [7:0] iob_s1 [CHIPS];
    logic [7:0] iob_s2 [CHIPS];
`else
    localparam logic IO_EN = 1'b0;
`endif

    // Unimplemented bits are dropped on write so they always read back as 0.
    function automatic logic [7:0] mask_reg(input logic [3:0] r, input logic [7:0] d);
        case (r)
            4'd1, 4'd3, 4'd5, 4'd13: mask_reg = {4'b0, d[3:0]};
            4'd6, 4'd8, 4'd9, 4'd10: mask_reg = {3'b0, d[4:0]};
            default:                 mask_reg = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHIPS; i++) begin
                for (int r = 0; r < 16; r++) regs_q[i][r] <= (r == 7) ? 8'hff : 8'h00;
                addr_q[i]      <= 4'h0;
                addr_ok_q[i]   <= 1'b1;
                env_restart[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHIPS; i++) begin
                env_restart[i] <= wr_tick & a0 & cs[i] & addr_ok_q[i] & (addr_q[i] == 4'd13);
                if (wr_tick && cs[i]) begin
                    if (!a0) begin
                        addr_q[i]    <= wdata[3:0];
                        addr_ok_q[i] <= (wdata[7:4] == ADDR_HI);
                    end else if (addr_ok_q[i] && (addr_q[i] < 4'd14 || IO_EN)) begin
                        regs_q[i][addr_q[i]] <= mask_reg(addr_q[i], wdata);
                    end
                end
            end
        end
    end

`ifdef AY_REGS_IO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHIPS; i++) begin
                ioa_s1[i] <= 8'h00;
                ioa_s2[i] <= 8'h00;
                iob_s1[i] <= 8'h00;
                iob_s2[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < CHIPS; i++) begin
                ioa_s1[i] <= ioa_in[i*8 +: 8];
                ioa_s2[i] <= ioa_s1[i];
                iob_s1[i] <= iob_in[i*8 +: 8];
                iob_s2[i] <= iob_s1[i];
            end
        end
    end
`endif

    // Lowest-index selected chip answers the read; everything else reads as an open bus.
    always_comb begin
        logic found;
        rd_val = 8'hff;
        found  = 1'b0;
        for (int i = 0; i < CHIPS; i++) begin
            if (cs[i] && !found) begin
                found = 1'b1;
                if (addr_ok_q[i]) begin
                    if (addr_q[i] < 4'd14) begin
                        rd_val = regs_q[i][addr_q[i]];
                    end
`ifdef AY_REGS_IO_EN
                    else if (addr_q[i] == 4'd14) begin
                        rd_val = regs_q[i][7][6] ? regs_q[i][14] : ioa_s2[i];
                    end else begin
                        rd_val = regs_q[i][7][7] ? regs_q[i][15] : iob_s2[i];
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= 8'h00;
        else if (rd_tick)
            rdata <= rd_val;
    end

    for (genvar g = 0; g < CHIPS; g++) begin : g_chip
        for (genvar r = 0; r < 14; r++) begin : g_reg
            assign regs_flat[g*112 + r*8 +: 8] = regs_q[g][r];
        end
`ifdef AY_REGS_IO_EN
        assign ioa_out[g*8 +: 8] = regs_q[g][14];
        assign iob_out[g*8 +: 8] = regs_q[g][15];
        assign ioa_oe[g]         = regs_q[g][7][6];
        assign iob_oe[g]         = regs_q[g][7][7];
`endif
    end

endmodule

// File: tb/tb_ay_regs_multi.sv
// Randomised self-checking bench for ay_regs_multi against a behavioural register-file model.
module tb_ay_regs_multi;

    localparam int CHIPS = 2;
    localparam int WID [16] = '{8, 4, 8, 4, 8, 4, 5, 8, 5, 5, 5, 8, 8, 4, 8, 8};

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [CHIPS-1:0]     cs = '0;
    logic                 a0 = 1'b0;
    logic                 wr_tick = 1'b0;
    logic [7:0]           wdata = 8'h00;
    logic                 rd_tick = 1'b0;
    logic [7:0]           rdata;
    logic [CHIPS*112-1:0] regs_flat;
    logic [CHIPS-1:0]     env_restart;
`ifdef AY_REGS_IO_EN
    logic [CHIPS*8-1:0]   ioa_in = '0;
    logic [CHIPS*8-1:0]   iob_in = '0;
    logic [CHIPS*8-1:0]   ioa_out;
    logic [CHIPS*8-1:0]   iob_out;
    logic [CHIPS-1:0]     ioa_oe;
    logic [CHIPS-1:0]     iob_oe;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]       m_regs [CHIPS][16];
    logic [3:0]       m_addr [CHIPS];
    bit               m_ok   [CHIPS];
    logic [CHIPS-1:0] m_env;

    ay_regs_multi #(.CHIPS(CHIPS), .ADDR_HI(4'h0)) dut (
        .clk(clk), .reset(reset), .cs(cs), .a0(a0), .wr_tick(wr_tick), .wdata(wdata),
        .rd_tick(rd_tick), .rdata(rdata), .regs_flat(regs_flat), .env_restart(env_restart)
`ifdef AY_REGS_IO_EN
        , .ioa_in(ioa_in), .iob_in(iob_in), .ioa_out(ioa_out), .iob_out(iob_out),
        .ioa_oe(ioa_oe), .iob_oe(iob_oe)
`endif
    );

    always #5 clk = ~clk;

`ifdef AY_REGS_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    task automatic model_reset();
        for (int i = 0; i < CHIPS; i++) begin
            for (int r = 0; r < 16; r++) m_regs[i][r] = (r == 7) ? 8'hff : 8'h00;
            m_addr[i] = 4'h0;
            m_ok[i]   = 1'b1;
        end
        m_env = '0;
    endtask

    task automatic model_write(input logic [CHIPS-1:0] c, input logic a, input logic [7:0] d);
        m_env = '0;
        for (int i = 0; i < CHIPS; i++) begin
            if (c[i]) begin
                if (!a) begin
                    m_addr[i] = d[3:0];
                    m_ok[i]   = (d[7:4] == 4'h0);
                end else if (m_ok[i]) begin
                    if (m_addr[i] < 14 || IO_EN)
                        m_regs[i][m_addr[i]] = d & 8'((1 << WID[m_addr[i]]) - 1);
                    if (m_addr[i] == 13) m_env[i] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [7:0] model_read(input logic [CHIPS-1:0] c);
        for (int i = 0; i < CHIPS; i++) begin
            if (c[i]) begin
                if (!m_ok[i]) return 8'hff;
                if (m_addr[i] < 14) return m_regs[i][m_addr[i]];
`ifdef AY_REGS_IO_EN
                if (m_addr[i] == 14) return m_regs[i][7][6] ? m_regs[i][14] : ioa_in[i*8 +: 8];
                return m_regs[i][7][7] ? m_regs[i][15] : iob_in[i*8 +: 8];
`else
                return 8'hff;
`endif
            end
        end
        return 8'hff;
    endfunction

    function automatic logic [CHIPS*112-1:0] model_flat();
        logic [CHIPS*112-1:0] f;
        for (int i = 0; i < CHIPS; i++)
            for (int r = 0; r < 14; r++) f[i*112 + r*8 +: 8] = m_regs[i][r];
        return f;
    endfunction

    task automatic bus_wr(input logic [CHIPS-1:0] c, input logic a, input logic [7:0] d);
        @(negedge clk);
        cs = c; a0 = a; wdata = d; wr_tick = 1'b1;
        model_write(c, a, d);
        @(negedge clk);
        wr_tick = 1'b0; cs = '0; a0 = 1'b0;
    endtask

    task automatic bus_rd(input logic [CHIPS-1:0] c, output logic [7:0] got, output logic [7:0] exp);
        @(negedge clk);
        cs = c; a0 = 1'b1; rd_tick = 1'b1;
        exp = model_read(c);
        @(negedge clk);
        rd_tick = 1'b0; cs = '0; a0 = 1'b0;
        got = rdata;
    endtask

    task automatic test_reset();
        logic [7:0] got, exp;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        checks++;
        if (env_restart !== '0) begin errors++; $display("FAIL reset_env got %b exp 0", env_restart); end
        checks++;
        if (regs_flat !== model_flat()) begin errors++; $display("FAIL reset_flat got %h exp %h", regs_flat, model_flat()); end
        for (int r = 0; r < 16; r++) begin
            bus_wr(2'b01, 1'b0, 8'(r));
            bus_rd(2'b01, got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_read_r%0d got %h exp %h", r, got, exp); end
        end
    endtask

    task automatic test_mask();
        logic [7:0] got, exp;
        bus_wr(2'b01, 1'b0, 8'h01);
        bus_wr(2'b01, 1'b1, 8'hff);
        bus_rd(2'b01, got, exp);
        checks++;
        if (got !== 8'h0f || exp !== 8'h0f) begin errors++; $display("FAIL mask_read got %h exp 0f", got); end
        checks++;
        if (regs_flat[15:8] !== 8'h0f) begin errors++; $display("FAIL mask_flat got %h exp 0f", regs_flat[15:8]); end
        checks++;
        if (regs_flat[112 + 15 -: 8] !== 8'h00) begin errors++; $display("FAIL mask_chip1 got %h exp 00", regs_flat[127:120]); end
        checks++;
        if (regs_flat !== model_flat()) begin errors++; $display("FAIL mask_all got %h exp %h", regs_flat, model_flat()); end
    endtask

    task automatic test_env();
        bus_wr(2'b11, 1'b0, 8'h0d);
        bus_wr(2'b11, 1'b1, 8'h0a);
        checks++;
        if (env_restart !== 2'b11) begin errors++; $display("FAIL env_pulse got %b exp 11", env_restart); end
        checks++;
        if (regs_flat[13*8 +: 8] !== 8'h0a || regs_flat[112 + 13*8 +: 8] !== 8'h0a) begin
            errors++; $display("FAIL env_r13 got %h/%h exp 0a", regs_flat[13*8 +: 8], regs_flat[112 + 13*8 +: 8]);
        end
        @(negedge clk);
        checks++;
        if (env_restart !== 2'b00) begin errors++; $display("FAIL env_single got %b exp 00", env_restart); end
    endtask

    task automatic test_addr_ok();
        logic [7:0] got, exp;
        bus_wr(2'b01, 1'b0, 8'h27);
        bus_wr(2'b01, 1'b1, 8'h00);
        checks++;
        if (regs_flat[7*8 +: 8] !== 8'hff) begin errors++; $display("FAIL addrhi_ignored got %h exp ff", regs_flat[63:56]); end
        bus_rd(2'b01, got, exp);
        checks++;
        if (got !== 8'hff) begin errors++; $display("FAIL addrhi_read got %h exp ff", got); end
        bus_wr(2'b01, 1'b0, 8'h07);
        bus_wr(2'b01, 1'b1, 8'h00);
        bus_rd(2'b01, got, exp);
        checks++;
        if (got !== 8'h00) begin errors++; $display("FAIL addr_r7_read got %h exp 00", got); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        bus_wr(2'b01, 1'b0, 8'h00);
        bus_wr(2'b01, 1'b1, 8'h12);
        @(negedge clk);
        cs = 2'b01; a0 = 1'b1; wdata = 8'h34; wr_tick = 1'b1; rd_tick = 1'b1;
        exp = model_read(2'b01);
        model_write(2'b01, 1'b1, 8'h34);
        @(negedge clk);
        wr_tick = 1'b0; rd_tick = 1'b0; cs = '0;
        checks++;
        if (rdata !== 8'h12 || exp !== 8'h12) begin errors++; $display("FAIL b2b_old got %h exp 12", rdata); end
        bus_rd(2'b01, got, exp);
        checks++;
        if (got !== 8'h34) begin errors++; $display("FAIL b2b_new got %h exp 34", got); end
        // address write and read in the same cycle: read must use the old address (R0)
        @(negedge clk);
        cs = 2'b01; a0 = 1'b0; wdata = 8'h07; wr_tick = 1'b1; rd_tick = 1'b1;
        model_write(2'b01, 1'b0, 8'h07);
        @(negedge clk);
        wr_tick = 1'b0; rd_tick = 1'b0; cs = '0; a0 = 1'b0;
        checks++;
        if (rdata !== 8'h34) begin errors++; $display("FAIL b2b_oldaddr got %h exp 34", rdata); end
        bus_rd(2'b00, got, exp);
        checks++;
        if (got !== 8'hff) begin errors++; $display("FAIL cs0_read got %h exp ff", got); end
        checks++;
        if (rdata !== 8'hff) begin errors++; $display("FAIL rdata_hold got %h exp ff", rdata); end
    endtask

`ifdef AY_REGS_IO_EN
    task automatic test_io();
        logic [7:0] got, exp;
        bus_wr(2'b01, 1'b0, 8'h07);
        bus_wr(2'b01, 1'b1, 8'h00);
        @(negedge clk);
        ioa_in[7:0] = 8'h5a;
        @(negedge clk);
        bus_wr(2'b01, 1'b0, 8'h0e);
        bus_rd(2'b01, got, exp);
        checks++;
        if (got !== 8'h5a) begin errors++; $display("FAIL io_pin_read got %h exp 5a", got); end
        checks++;
        if (ioa_oe[0] !== 1'b0) begin errors++; $display("FAIL io_oe_off got %b exp 0", ioa_oe[0]); end
        bus_wr(2'b01, 1'b0, 8'h07);
        bus_wr(2'b01, 1'b1, 8'h40);
        bus_wr(2'b01, 1'b0, 8'h0e);
        bus_wr(2'b01, 1'b1, 8'hc3);
        checks++;
        if (ioa_out[7:0] !== 8'hc3 || ioa_oe[0] !== 1'b1) begin
            errors++; $display("FAIL io_latch got %h/%b exp c3/1", ioa_out[7:0], ioa_oe[0]);
        end
        bus_rd(2'b01, got, exp);
        checks++;
        if (got !== 8'hc3) begin errors++; $display("FAIL io_latch_read got %h exp c3", got); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] got, exp, d;
        logic [CHIPS-1:0] c;
        for (int n = 0; n < 300; n++) begin
            c = CHIPS'($urandom_range(0, (1 << CHIPS) - 1));
            case ($urandom_range(0, 2))
                0: begin
                    d = {($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0, 4'($urandom)};
                    bus_wr(c, 1'b0, d);
                end
                1: begin
                    bus_wr(c, 1'b1, 8'($urandom));
                    checks++;
                    if (env_restart !== m_env) begin errors++; $display("FAIL rnd_env n=%0d got %b exp %b", n, env_restart, m_env); end
                    checks++;
                    if (regs_flat !== model_flat()) begin errors++; $display("FAIL rnd_flat n=%0d got %h exp %h", n, regs_flat, model_flat()); end
                end
                default: begin
                    bus_rd(c, got, exp);
                    checks++;
                    if (got !== exp) begin errors++; $display("FAIL rnd_read n=%0d cs=%b got %h exp %h", n, c, got, exp); end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        bus_wr(2'b11, 1'b0, 8'h03);
        bus_wr(2'b11, 1'b1, 8'h09);
        bus_wr(2'b10, 1'b0, 8'h0d);
        @(negedge clk);
        reset = 1'b1; cs = 2'b10; a0 = 1'b1; wdata = 8'h05; wr_tick = 1'b1; rd_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0; wr_tick = 1'b0; rd_tick = 1'b0; cs = '0; a0 = 1'b0;
        model_reset();
        checks++;
        if (regs_flat !== model_flat()) begin errors++; $display("FAIL rstmid_flat got %h exp %h", regs_flat, model_flat()); end
        checks++;
        if (rdata !== 8'h00 || env_restart !== '0) begin errors++; $display("FAIL rstmid_out got %h/%b exp 00/0", rdata, env_restart); end
        // address returns to R0 with addr_ok set, so chip 1 reads its R0
        bus_rd(2'b10, got, exp);
        checks++;
        if (got !== 8'h00) begin errors++; $display("FAIL rstmid_read got %h exp 00", got); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mask();
        test_env();
        test_addr_ok();
        test_back_to_back();
`ifdef AY_REGS_IO_EN
        test_io();
        @(negedge clk);
        ioa_in = 16'($urandom);
        iob_in = 16'($urandom);
        repeat (3) @(negedge clk);
`endif
        test_random();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
